// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_pkg
// Description : Shared constants and types for the instruction fetch unit.
//               RESET_PC_DEFAULT : first fetch address after reset
//               INSTR_HALT       : fetched word that ends the program
//               PC_STEP          : sequential PC increment (one word)
//               PC_R15_OFFSET    : PC-to-R15 read offset (ARM pipeline view)
// Revision    : 1.0 - initial release
// ============================================================================
package fetch_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h2000_4000;
    localparam logic [31:0] INSTR_HALT       = 32'h0000_0000;
    localparam int          PC_STEP          = 4;
    localparam int          PC_R15_OFFSET    = 8;

    // Fetch control state.
    typedef enum logic [0:0] {
        RUN  = 1'b0,
        HALT = 1'b1
    } fetch_state_e;

    // Next-PC source select for the PC register.
    typedef enum logic [1:0] {
        PC_HOLD = 2'd0,
        PC_INC  = 2'd1,
        PC_LOAD = 2'd2
    } pc_sel_e;

endpackage : fetch_pkg
`default_nettype wire

// File: rtl/instruction_fetch_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : instruction_fetch_unit_if
// Description : Bundles the fetch unit's memory, redirect and decode-side
//               handshake signals.
//               master : fetch unit (drives address and Out_* / Halted)
//               slave  : environment (memory, branch unit, decode)
// Revision    : 1.0 - initial release
// ============================================================================
interface instruction_fetch_unit_if #(
    parameter int DATAWIDTH = 32
);
    // Instruction memory
    logic [DATAWIDTH-1:0] Inst_Address;
    logic [DATAWIDTH-1:0] Instr_In;
    // Branch redirect
    logic                 Redirect_Valid;
    logic [DATAWIDTH-1:0] Redirect_Target;
    // Decode handshake
    logic                 Out_Ready;
    logic                 Out_Valid;
    logic [DATAWIDTH-1:0] Out_Instr;
    logic [DATAWIDTH-1:0] Out_PC;
    logic [DATAWIDTH-1:0] Out_PC_Plus8;
    // Status
    logic                 Halted;

    modport master (
        output Inst_Address,
        input  Instr_In,
        input  Redirect_Valid,
        input  Redirect_Target,
        input  Out_Ready,
        output Out_Valid,
        output Out_Instr,
        output Out_PC,
        output Out_PC_Plus8,
        output Halted
    );

    modport slave (
        input  Inst_Address,
        output Instr_In,
        output Redirect_Valid,
        output Redirect_Target,
        output Out_Ready,
        input  Out_Valid,
        input  Out_Instr,
        input  Out_PC,
        input  Out_PC_Plus8,
        input  Halted
    );

endinterface : instruction_fetch_unit_if
`default_nettype wire

// File: rtl/fetch_pc_reg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_pc_reg
// Description : Program counter register with hold / increment / load select.
//               clk, reset  : clock, synchronous active-high reset
//               pc_sel      : next-PC source (PC_HOLD, PC_INC, PC_LOAD)
//               load_target : redirect address (low two bits forced to 0)
//               pc          : current PC
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_pc_reg
    import fetch_pkg::*;
#(
    parameter int                   DATAWIDTH = 32,
    parameter logic [DATAWIDTH-1:0] RESET_PC  = RESET_PC_DEFAULT
) (
    input  wire logic                 clk,
    input  wire logic                 reset,
    input  wire pc_sel_e              pc_sel,
    input  wire logic [DATAWIDTH-1:0] load_target,
    output logic      [DATAWIDTH-1:0] pc
);

    localparam logic [DATAWIDTH-1:0] c_step       = DATAWIDTH'(PC_STEP);
    localparam logic [DATAWIDTH-1:0] c_align_mask = ~DATAWIDTH'(3);

    logic [DATAWIDTH-1:0] r_pc;
    logic [DATAWIDTH-1:0] w_target_aligned;

    // Redirect targets are always word aligned.
    assign w_target_aligned = load_target & c_align_mask;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc <= RESET_PC;
        end else begin
            case (pc_sel)
                PC_INC:  r_pc <= r_pc + c_step;   // wraps modulo 2^DATAWIDTH
                PC_LOAD: r_pc <= w_target_aligned;
                default: r_pc <= r_pc;
            endcase
        end
    end

    assign pc = r_pc;

endmodule : fetch_pc_reg
`default_nettype wire

// File: rtl/instruction_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : instruction_fetch_unit
// Description : Issues PC to a combinational instruction memory, registers
//               the returned word with its PC and PC+8 and offers them to
//               decode over a valid/ready handshake. Handles redirects,
//               back-pressure and halting on an all-zero word.
//               clk, reset : clock, synchronous active-high reset
//               bus        : master side of instruction_fetch_unit_if
//                            (Inst_Address/Instr_In, Redirect_*, Out_*,
//                            Halted)
// Revision    : 1.0 - initial release
// ============================================================================
module instruction_fetch_unit
    import fetch_pkg::*;
#(
    parameter int                   DATAWIDTH    = 32,
    parameter logic [DATAWIDTH-1:0] RESET_PC     = RESET_PC_DEFAULT,
    parameter bit                   HALT_ON_ZERO = 1'b1
) (
    input  wire logic                 clk,
    input  wire logic                 reset,
    instruction_fetch_unit_if.master  bus
);

    localparam logic [DATAWIDTH-1:0] c_r15_offset = DATAWIDTH'(PC_R15_OFFSET);
    localparam logic [DATAWIDTH-1:0] c_halt_word  = DATAWIDTH'(INSTR_HALT);

    fetch_state_e         r_state;
    fetch_state_e         w_state_next;
    pc_sel_e              w_pc_sel;
    logic [DATAWIDTH-1:0] w_pc;

    logic                 r_out_valid;
    logic [DATAWIDTH-1:0] r_out_instr;
    logic [DATAWIDTH-1:0] r_out_pc;
    logic [DATAWIDTH-1:0] r_out_pc8;

    logic                 w_slot_free;
    logic                 w_zero_word;
    logic                 w_capture;
    logic                 w_clear_valid;

    // ------------------------------------------------------------------
    // PC register
    // ------------------------------------------------------------------
    fetch_pc_reg #(
        .DATAWIDTH (DATAWIDTH),
        .RESET_PC  (RESET_PC)
    ) u_pc_reg (
        .clk         (clk),
        .reset       (reset),
        .pc_sel      (w_pc_sel),
        .load_target (bus.Redirect_Target),
        .pc          (w_pc)
    );

    // The output slot can take a new word when empty or being drained now.
    assign w_slot_free = !r_out_valid || bus.Out_Ready;

    generate
        if (HALT_ON_ZERO) begin : g_halt_on_zero
            assign w_zero_word = (bus.Instr_In == c_halt_word);
        end else begin : g_no_halt
            assign w_zero_word = 1'b0;
        end
    endgenerate

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= RUN;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state and datapath controls
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next  = r_state;
        w_pc_sel      = PC_HOLD;
        w_capture     = 1'b0;
        w_clear_valid = 1'b0;

        if (bus.Redirect_Valid) begin
            // Redirect flushes the slot even under back-pressure and wakes
            // fetch from HALT.
            w_pc_sel      = PC_LOAD;
            w_clear_valid = 1'b1;
            w_state_next  = RUN;
        end else begin
            case (r_state)
                RUN: begin
                    if (w_slot_free) begin
                        if (w_zero_word) begin
                            // End of program: the zero word is not emitted
                            // and the PC stays on its address.
                            w_clear_valid = 1'b1;
                            w_state_next  = HALT;
                        end else begin
                            w_capture = 1'b1;
                            w_pc_sel  = PC_INC;
                        end
                    end
                end
                HALT: begin
                    // Let any pending entry drain; never fetch.
                    if (w_slot_free) begin
                        w_clear_valid = 1'b1;
                    end
                end
                default: begin
                    w_state_next = RUN;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Output register (data held while valid and not accepted)
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_out_valid <= 1'b0;
            r_out_instr <= '0;
            r_out_pc    <= '0;
            r_out_pc8   <= '0;
        end else if (w_capture) begin
            r_out_valid <= 1'b1;
            r_out_instr <= bus.Instr_In;
            r_out_pc    <= w_pc;
            r_out_pc8   <= w_pc + c_r15_offset;
        end else if (w_clear_valid) begin
            r_out_valid <= 1'b0;
        end
    end

    assign bus.Inst_Address = w_pc;
    assign bus.Out_Valid    = r_out_valid;
    assign bus.Out_Instr    = r_out_instr;
    assign bus.Out_PC       = r_out_pc;
    assign bus.Out_PC_Plus8 = r_out_pc8;
    assign bus.Halted       = (r_state == HALT);

endmodule : instruction_fetch_unit
`default_nettype wire

// File: tb/tb_instruction_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_instruction_fetch_unit
// Description : Self-checking bench for instruction_fetch_unit. DUT u_dut1
//               runs a 13-word program at the default reset PC; u_dut2
//               starts at 32'hFFFFFFFC with HALT_ON_ZERO=0 to cover PC wrap
//               and zero-word emission.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instruction_fetch_unit;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pc8;
    } exp_t;

    logic clk;
    logic reset;
    logic reset2;

    int checks = 0;
    int errors = 0;

    exp_t q1[$];
    exp_t q2[$];

    logic [31:0] prog [0:12];

    instruction_fetch_unit_if #(.DATAWIDTH(32)) b1 ();
    instruction_fetch_unit_if #(.DATAWIDTH(32)) b2 ();

    instruction_fetch_unit #(
        .DATAWIDTH    (32),
        .RESET_PC     (32'h2000_4000),
        .HALT_ON_ZERO (1'b1)
    ) u_dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (b1)
    );

    instruction_fetch_unit #(
        .DATAWIDTH    (32),
        .RESET_PC     (32'hFFFF_FFFC),
        .HALT_ON_ZERO (1'b0)
    ) u_dut2 (
        .clk   (clk),
        .reset (reset2),
        .bus   (b2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        prog[0]  = 32'hE590_1004; prog[1]  = 32'hE590_2008;
        prog[2]  = 32'hE281_3002; prog[3]  = 32'hE083_4002;
        prog[4]  = 32'hE244_4001; prog[5]  = 32'hE354_0000;
        prog[6]  = 32'h1AFF_FFFC; prog[7]  = 32'hE581_3008;
        prog[8]  = 32'hE283_3001; prog[9]  = 32'hE1A0_5003;
        prog[10] = 32'hE085_5004; prog[11] = 32'hE581_5010;
        prog[12] = 32'hE580_200C;
    end

    function automatic logic [31:0] mem1(input logic [31:0] a);
        logic [31:0] off;
        off = a - 32'h2000_4000;
        if (a >= 32'h2000_4000 && off <= 32'h30 && off[1:0] == 2'b00)
            return prog[off[5:2]];
        return 32'h0;
    endfunction

    function automatic logic [31:0] mem2(input logic [31:0] a);
        if (a == 32'h4) return 32'h0;
        return {a[31:2], 2'b01} ^ 32'hE000_0000;
    endfunction

    function automatic exp_t mk1(input logic [31:0] pc);
        return {mem1(pc), pc, pc + 32'd8};
    endfunction

    function automatic exp_t mk2(input logic [31:0] pc);
        return {mem2(pc), pc, pc + 32'd8};
    endfunction

    assign b1.Instr_In = mem1(b1.Inst_Address);
    assign b2.Instr_In = mem2(b2.Inst_Address);

    // Sample the handshake just before an edge, then advance one cycle.
    task automatic step1(output bit x, output exp_t o);
        x = (b1.Out_Valid === 1'b1) && (b1.Out_Ready === 1'b1);
        o = {b1.Out_Instr, b1.Out_PC, b1.Out_PC_Plus8};
        @(posedge clk); #1;
    endtask

    task automatic step2(output bit x, output exp_t o);
        x = (b2.Out_Valid === 1'b1) && (b2.Out_Ready === 1'b1);
        o = {b2.Out_Instr, b2.Out_PC, b2.Out_PC_Plus8};
        @(posedge clk); #1;
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset();
        reset = 1'b1;
        b1.Redirect_Valid = 1'b0; b1.Redirect_Target = '0; b1.Out_Ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (b1.Inst_Address !== 32'h2000_4000 || b1.Out_Valid !== 1'b0 ||
            b1.Halted !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctl addr=%h valid=%b halted=%b want 20004000/0/0",
                     b1.Inst_Address, b1.Out_Valid, b1.Halted);
        end
        checks++;
        if (b1.Out_Instr !== 32'h0 || b1.Out_PC !== 32'h0 || b1.Out_PC_Plus8 !== 32'h0) begin
            errors++;
            $display("FAIL reset_data instr=%h pc=%h pc8=%h want all 0",
                     b1.Out_Instr, b1.Out_PC, b1.Out_PC_Plus8);
        end
        reset = 1'b0;
    endtask

    // ------------------------------------------------------------------
    task automatic test_fetch_latency();
        bit x; exp_t o; exp_t e;
        b1.Out_Ready = 1'b1;
        q1.push_back(mk1(32'h2000_4000));
        q1.push_back(mk1(32'h2000_4004));
        step1(x, o);
        checks++;
        if (x) begin
            errors++;
            $display("FAIL first_xfer_early got transfer want none");
        end
        checks++;
        if (b1.Out_Valid !== 1'b1 || b1.Out_Instr !== 32'hE590_1004 ||
            b1.Out_PC !== 32'h2000_4000 || b1.Out_PC_Plus8 !== 32'h2000_4008) begin
            errors++;
            $display("FAIL first_fetch v=%b instr=%h pc=%h pc8=%h want 1/E5901004/20004000/20004008",
                     b1.Out_Valid, b1.Out_Instr, b1.Out_PC, b1.Out_PC_Plus8);
        end
        step1(x, o);
        checks++;
        if (!x || q1.size() == 0) begin
            errors++;
            $display("FAIL fetch_xfer transfer=%b want 1", x);
        end else begin
            e = q1.pop_front();
            if (o !== e) begin
                errors++;
                $display("FAIL fetch_xfer got %h/%h/%h want %h/%h/%h",
                         o.instr, o.pc, o.pc8, e.instr, e.pc, e.pc8);
            end
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_stall();
        bit x; exp_t o; exp_t e; exp_t hold;
        checks++;
        if (b1.Out_Valid !== 1'b1 || b1.Out_Instr !== 32'hE590_2008) begin
            errors++;
            $display("FAIL stall_pre v=%b instr=%h want 1/E5902008", b1.Out_Valid, b1.Out_Instr);
        end
        hold = {b1.Out_Instr, b1.Out_PC, b1.Out_PC_Plus8};
        b1.Out_Ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step1(x, o);
            checks++;
            if (x || b1.Out_Valid !== 1'b1 ||
                {b1.Out_Instr, b1.Out_PC, b1.Out_PC_Plus8} !== hold ||
                b1.Inst_Address !== 32'h2000_4008) begin
                errors++;
                $display("FAIL stall_hold cyc=%0d v=%b instr=%h pc=%h addr=%h want 1/%h/%h/20004008",
                         i, b1.Out_Valid, b1.Out_Instr, b1.Out_PC, b1.Inst_Address,
                         hold.instr, hold.pc);
            end
        end
        b1.Out_Ready = 1'b1;
        step1(x, o);
        checks++;
        if (!x || q1.size() == 0) begin
            errors++;
            $display("FAIL stall_release transfer=%b want 1", x);
        end else begin
            e = q1.pop_front();
            if (o !== e) begin
                errors++;
                $display("FAIL stall_release got %h/%h/%h want %h/%h/%h",
                         o.instr, o.pc, o.pc8, e.instr, e.pc, e.pc8);
            end
        end
        checks++;
        if (b1.Out_Valid !== 1'b1 || b1.Out_Instr !== 32'hE281_3002 ||
            b1.Out_PC !== 32'h2000_4008) begin
            errors++;
            $display("FAIL no_gap v=%b instr=%h pc=%h want 1/E2813002/20004008",
                     b1.Out_Valid, b1.Out_Instr, b1.Out_PC);
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_redirect();
        bit x; exp_t o;
        b1.Out_Ready = 1'b0;
        b1.Redirect_Valid = 1'b1;
        b1.Redirect_Target = 32'h2000_4012;
        step1(x, o);
        b1.Redirect_Valid = 1'b0;
        checks++;
        if (b1.Out_Valid !== 1'b0 || b1.Inst_Address !== 32'h2000_4010) begin
            errors++;
            $display("FAIL redirect_flush v=%b addr=%h want 0/20004010",
                     b1.Out_Valid, b1.Inst_Address);
        end
        b1.Out_Ready = 1'b1;
        for (int a = 32'h2000_4010; a <= 32'h2000_4030; a += 4)
            q1.push_back(mk1(32'(a)));
        step1(x, o);
        checks++;
        if (x || b1.Out_Valid !== 1'b1 || b1.Out_Instr !== 32'hE244_4001 ||
            b1.Out_PC !== 32'h2000_4010) begin
            errors++;
            $display("FAIL redirect_target xfer=%b v=%b instr=%h pc=%h want 0/1/E2444001/20004010",
                     x, b1.Out_Valid, b1.Out_Instr, b1.Out_PC);
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_run_to_end(input int exp_count, input bit random_bp);
        bit x; exp_t o; exp_t e;
        int n = 0;
        int budget = 200;
        while (!(b1.Halted === 1'b1 && b1.Out_Valid === 1'b0) && budget > 0) begin
            b1.Out_Ready = random_bp ? 1'($urandom_range(0, 1)) : 1'b1;
            step1(x, o);
            budget--;
            if (x) begin
                n++;
                checks++;
                if (q1.size() == 0) begin
                    errors++;
                    $display("FAIL run_xfer unexpected %h at %h", o.instr, o.pc);
                end else begin
                    e = q1.pop_front();
                    if (o !== e) begin
                        errors++;
                        $display("FAIL run_xfer got %h/%h/%h want %h/%h/%h",
                                 o.instr, o.pc, o.pc8, e.instr, e.pc, e.pc8);
                    end
                end
            end
        end
        b1.Out_Ready = 1'b1;
        checks++;
        if (budget == 0 || n != exp_count || q1.size() != 0) begin
            errors++;
            $display("FAIL run_count emitted=%0d left=%0d budget=%0d want %0d/0/>0",
                     n, q1.size(), budget, exp_count);
        end
        checks++;
        if (b1.Halted !== 1'b1 || b1.Inst_Address !== 32'h2000_4034) begin
            errors++;
            $display("FAIL halt_state halted=%b addr=%h want 1/20004034",
                     b1.Halted, b1.Inst_Address);
        end
        for (int i = 0; i < 3; i++) begin
            step1(x, o);
            checks++;
            if (x || b1.Out_Valid !== 1'b0 || b1.Halted !== 1'b1 ||
                b1.Inst_Address !== 32'h2000_4034) begin
                errors++;
                $display("FAIL halt_hold v=%b halted=%b addr=%h want 0/1/20004034",
                         b1.Out_Valid, b1.Halted, b1.Inst_Address);
            end
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_halt_redirect();
        bit x; exp_t o;
        b1.Redirect_Valid = 1'b1;
        b1.Redirect_Target = 32'h2000_4000;
        step1(x, o);
        b1.Redirect_Valid = 1'b0;
        checks++;
        if (b1.Halted !== 1'b0 || b1.Inst_Address !== 32'h2000_4000 || b1.Out_Valid !== 1'b0) begin
            errors++;
            $display("FAIL halt_exit halted=%b addr=%h v=%b want 0/20004000/0",
                     b1.Halted, b1.Inst_Address, b1.Out_Valid);
        end
        for (int a = 32'h2000_4000; a <= 32'h2000_4030; a += 4)
            q1.push_back(mk1(32'(a)));
        step1(x, o);
        checks++;
        if (b1.Out_Valid !== 1'b1 || b1.Out_Instr !== 32'hE590_1004) begin
            errors++;
            $display("FAIL halt_reemit v=%b instr=%h want 1/E5901004",
                     b1.Out_Valid, b1.Out_Instr);
        end
        test_run_to_end(13, 1'b1);
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset_mid_redirect();
        bit x; exp_t o;
        reset = 1'b1;
        b1.Redirect_Valid = 1'b1;
        b1.Redirect_Target = 32'h2000_4020;
        b1.Out_Ready = 1'b0;
        step1(x, o);
        checks++;
        if (b1.Inst_Address !== 32'h2000_4000 || b1.Out_Valid !== 1'b0 ||
            b1.Halted !== 1'b0 || b1.Out_PC !== 32'h0 || b1.Out_Instr !== 32'h0) begin
            errors++;
            $display("FAIL reset_over_redirect addr=%h v=%b halted=%b pc=%h instr=%h want 20004000/0/0/0/0",
                     b1.Inst_Address, b1.Out_Valid, b1.Halted, b1.Out_PC, b1.Out_Instr);
        end
        reset = 1'b0;
        b1.Redirect_Valid = 1'b0;
        q1.delete();
    endtask

    // ------------------------------------------------------------------
    task automatic test_wrap();
        bit x; exp_t o; exp_t e; exp_t hold;
        reset2 = 1'b1;
        b2.Redirect_Valid = 1'b0; b2.Redirect_Target = '0; b2.Out_Ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (b2.Inst_Address !== 32'hFFFF_FFFC || b2.Out_Valid !== 1'b0) begin
            errors++;
            $display("FAIL wrap_reset addr=%h v=%b want FFFFFFFC/0", b2.Inst_Address, b2.Out_Valid);
        end
        reset2 = 1'b0;
        b2.Out_Ready = 1'b1;
        q2.push_back(mk2(32'hFFFF_FFFC));
        q2.push_back(mk2(32'h0000_0000));
        q2.push_back(mk2(32'h0000_0004));
        step2(x, o);
        checks++;
        if (b2.Out_PC !== 32'hFFFF_FFFC || b2.Out_PC_Plus8 !== 32'h0000_0004) begin
            errors++;
            $display("FAIL wrap_pc8 pc=%h pc8=%h want FFFFFFFC/00000004", b2.Out_PC, b2.Out_PC_Plus8);
        end
        for (int i = 0; i < 3; i++) begin
            step2(x, o);
            checks++;
            if (!x || q2.size() == 0) begin
                errors++;
                $display("FAIL wrap_xfer cyc=%0d transfer=%b want 1", i, x);
            end else begin
                e = q2.pop_front();
                if (o !== e) begin
                    errors++;
                    $display("FAIL wrap_xfer got %h/%h/%h want %h/%h/%h",
                             o.instr, o.pc, o.pc8, e.instr, e.pc, e.pc8);
                end
            end
        end
        checks++;
        if (b2.Halted !== 1'b0 || b2.Out_PC !== 32'h0000_0008) begin
            errors++;
            $display("FAIL zero_emitted halted=%b pc=%h want 0/00000008", b2.Halted, b2.Out_PC);
        end
        hold = {b2.Out_Instr, b2.Out_PC, b2.Out_PC_Plus8};
        b2.Out_Ready = 1'b0;
        repeat (2) step2(x, o);
        checks++;
        if ({b2.Out_Instr, b2.Out_PC, b2.Out_PC_Plus8} !== hold || b2.Inst_Address !== 32'h0000_000C) begin
            errors++;
            $display("FAIL wrap_stall pc=%h addr=%h want %h/0000000C", b2.Out_PC, b2.Inst_Address, hold.pc);
        end
        reset2 = 1'b1;
        step2(x, o);
        checks++;
        if (b2.Inst_Address !== 32'hFFFF_FFFC || b2.Out_Valid !== 1'b0 || b2.Halted !== 1'b0 ||
            b2.Out_Instr !== 32'h0 || b2.Out_PC !== 32'h0 || b2.Out_PC_Plus8 !== 32'h0) begin
            errors++;
            $display("FAIL reset_mid_stall addr=%h v=%b instr=%h pc=%h pc8=%h want FFFFFFFC/0/0/0/0",
                     b2.Inst_Address, b2.Out_Valid, b2.Out_Instr, b2.Out_PC, b2.Out_PC_Plus8);
        end
        reset2 = 1'b0;
    endtask

    // ------------------------------------------------------------------
    initial begin
        reset2 = 1'b1;
        b2.Redirect_Valid = 1'b0; b2.Redirect_Target = '0; b2.Out_Ready = 1'b0;
        test_reset();
        test_fetch_latency();
        test_stall();
        test_redirect();
        test_run_to_end(9, 1'b0);
        test_halt_redirect();
        test_reset_mid_redirect();
        test_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

endmodule : tb_instruction_fetch_unit
`default_nettype wire

// File: doc/instruction_fetch_unit.md
# instruction_fetch_unit

- Issuing side of the instruction-memory interface in the single-cycle ARM datapath.
- Holds the program counter and drives it as the 32-bit word address into the combinational instruction memory.
- Registers the returned instruction together with its PC and PC+8, and offers them to decode over a valid/ready handshake.
- Handles branch redirects, back-pressure and end-of-program halt (memory returns all-zero word).

## Interface

- DATAWIDTH, 32, width of addresses and instructions
- RESET_PC, 32'h20004000, first fetch address after reset
- HALT_ON_ZERO, 1, when 1 an all-zero fetched word halts fetch
- clk  input  1  single clock; all state updates on rising edge
- reset  input  1  synchronous, active-high
- Inst_Address  output  DATAWIDTH  current PC, to instruction memory
- Instr_In  input  DATAWIDTH  word returned combinationally for Inst_Address in the same cycle
- Redirect_Valid  input  1  branch taken; load Redirect_Target
- Redirect_Target  input  DATAWIDTH  new PC; bits [1:0] ignored (forced 0)
- Out_Ready  input  1  decode accepts this cycle
- Out_Valid  output  1  Out_* hold a valid fetched instruction
- Out_Instr  output  DATAWIDTH  fetched instruction
- Out_PC  output  DATAWIDTH  address of Out_Instr
- Out_PC_Plus8  output  DATAWIDTH  Out_PC+8 (architectural R15 read value)
- Halted  output  1  fetch stopped on zero word

## Operation

- States: RUN, HALT. Reset enters RUN.
- Transfer: Out_Valid && Out_Ready. Slot free: !Out_Valid || Out_Ready.
- Capture (RUN, !Redirect_Valid, slot free): Out_Instr←Instr_In, Out_PC←PC, Out_PC_Plus8←PC+8, Out_Valid←1, PC←PC+4.
- RUN, !Redirect_Valid, slot not free: PC and all Out_* hold. Out_* must not change while Out_Valid=1 and Out_Ready=0.
- RUN, no capture, slot free (transfer without replacement): Out_Valid←0.
- Redirect_Valid (any state, highest priority after reset):
  - PC←{Redirect_Target[31:2],2'b00}.
  - Out_Valid←0 (flush, even if Out_Ready=0).
  - No capture that cycle.
  - State←RUN, Halted←0.
- Zero word (HALT_ON_ZERO=1, capture condition met, Instr_In==0):
  - Not emitted: Out_Valid←0 if slot free, otherwise any pending entry stays valid until transferred.
  - PC holds the zero-word address.
  - State←HALT, Halted←1.
- HALT: no fetches; PC constant; pending Out_* entry still drains via handshake; leaves only on Redirect_Valid or reset.
- HALT_ON_ZERO=0: zero word is emitted like any instruction.
- Arithmetic: PC+4 and PC+8 are modulo 2^DATAWIDTH; 32'hFFFFFFFC+4 wraps to 0, and Out_PC_Plus8 of 32'hFFFFFFFC is 32'h00000004.

## Timing

- Reset values (after the reset edge):
  - Inst_Address=RESET_PC.
  - Out_Valid=0, Out_Instr=0, Out_PC=0, Out_PC_Plus8=0.
  - Halted=0, state RUN.
- Reset asserted mid-stall or mid-redirect overrides everything.
- Fetch latency: instruction at PC is on Out_* one cycle after Inst_Address=PC, given the slot is free.
- Throughput: one instruction per cycle while Out_Ready=1.
- Redirect latency: Redirect_Valid at edge n gives Inst_Address=target after n and Out_Valid=1 with the target instruction after n+1.
- Instr_In is sampled only at the capture edge; no combinational path from Instr_In to any output.

## Structure

- Shared package fetch_pkg holds:
  - RESET_PC default.
  - INSTR_HALT (32'h0).
  - PC_STEP (4) and PC_R15_OFFSET (8).
  - Fetch state enum {RUN, HALT}.
- One natural sub-module: fetch_pc_reg, the PC register with increment/redirect/hold select.
- Output register and FSM live in the top.

## Test plan

- Reset then Out_Ready=1:
  - Cycle 1: Inst_Address=20004000.
  - Cycle 2: Out_Valid=1, Out_Instr=E5901004, Out_PC=20004000, Out_PC_Plus8=20004008.
  - Next: E5902008 at 20004004.
- Out_Ready=0 for 3 cycles while Out_Instr=E5902008:
  - Out_* constant, Inst_Address holds 20004008.
  - On release, E2813002 follows with no gap.
- Redirect_Valid with target 20004012 while Out_Valid=1, Out_Ready=0:
  - Next cycle Out_Valid=0, Inst_Address=20004010.
  - Following cycle Out_Instr=E2444001.
- Run program to end:
  - 13 instructions emitted (last E580200C at 2000402C + 4 = 20004030).
  - Memory returns 0 at 20004034, so Halted=1, Inst_Address stays 20004034, Out_Valid=0 after the last transfer.
- From HALT, Redirect_Target=20004000:
  - Halted=0 next cycle.
  - E5901004 re-emitted one cycle later.
- RESET_PC=FFFFFFFC, memory returns nonzero:
  - Out_PC=FFFFFFFC with Out_PC_Plus8=00000004.
  - Next Out_PC=00000000.
  - reset asserted mid-stall restores all reset values.
